// File: rtl/instr_encoder_pkg.sv
// Op-class codes, MIPS opcode/funct constants and field-packing helpers
// shared by the instruction encoder and the main decoder / ALU control.
package instr_encoder_pkg;

    localparam logic [3:0] CLS_ADD   = 4'd0;
    localparam logic [3:0] CLS_SUB   = 4'd1;
    localparam logic [3:0] CLS_AND   = 4'd2;
    localparam logic [3:0] CLS_OR    = 4'd3;
    localparam logic [3:0] CLS_SLT   = 4'd4;
    localparam logic [3:0] CLS_ADDI  = 4'd5;
    localparam logic [3:0] CLS_SLTIU = 4'd6;
    localparam logic [3:0] CLS_ORI   = 4'd7;
    localparam logic [3:0] CLS_LUI   = 4'd8;
    localparam logic [3:0] CLS_LW    = 4'd9;
    localparam logic [3:0] CLS_SW    = 4'd10;
    localparam logic [3:0] CLS_BEQ   = 4'd11;
    localparam logic [3:0] CLS_BNE   = 4'd12;
    localparam logic [3:0] CLS_J     = 4'd13;
    localparam logic [3:0] CLS_JAL   = 4'd14;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_SLTIU = 6'd9;
    localparam logic [5:0] OP_ORI   = 6'd13;
    localparam logic [5:0] OP_LUI   = 6'd15;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [5:0] FN_ADD = 6'd32;
    localparam logic [5:0] FN_SUB = 6'd34;
    localparam logic [5:0] FN_AND = 6'd36;
    localparam logic [5:0] FN_OR  = 6'd37;
    localparam logic [5:0] FN_SLT = 6'd42;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FULL = 2'd2;

    function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [5:0] fn);
        return {OP_RTYPE, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

endpackage

// File: rtl/instr_encoder_pack.sv
// Combinational packer: op class plus register/immediate fields -> 32-bit MIPS word.
module instr_word_pack
    import instr_encoder_pkg::*;
(
    input  logic [3:0]  i_cls,
    input  logic [4:0]  i_rs,
    input  logic [4:0]  i_rt,
    input  logic [4:0]  i_rd,
    input  logic [15:0] i_imm,
    input  logic [25:0] i_target,
    output logic [31:0] o_word,
    output logic        o_illegal
);

    always_comb begin
        o_word    = 32'd0;
        o_illegal = 1'b0;
        case (i_cls)
            CLS_ADD:   o_word = r_word(i_rs, i_rt, i_rd, FN_ADD);
            CLS_SUB:   o_word = r_word(i_rs, i_rt, i_rd, FN_SUB);
            CLS_AND:   o_word = r_word(i_rs, i_rt, i_rd, FN_AND);
            CLS_OR:    o_word = r_word(i_rs, i_rt, i_rd, FN_OR);
            CLS_SLT:   o_word = r_word(i_rs, i_rt, i_rd, FN_SLT);
            CLS_ADDI:  o_word = i_word(OP_ADDI,  i_rs, i_rt, i_imm);
            CLS_SLTIU: o_word = i_word(OP_SLTIU, i_rs, i_rt, i_imm);
            CLS_ORI:   o_word = i_word(OP_ORI,   i_rs, i_rt, i_imm);
            // LUI has no source register; rs is encoded as zero
            CLS_LUI:   o_word = i_word(OP_LUI,   5'd0, i_rt, i_imm);
            CLS_LW:    o_word = i_word(OP_LW,    i_rs, i_rt, i_imm);
            CLS_SW:    o_word = i_word(OP_SW,    i_rs, i_rt, i_imm);
            CLS_BEQ:   o_word = i_word(OP_BEQ,   i_rs, i_rt, i_imm);
            CLS_BNE:   o_word = i_word(OP_BNE,   i_rs, i_rt, i_imm);
            CLS_J:     o_word = {OP_J,   i_target};
            CLS_JAL:   o_word = {OP_JAL, i_target};
            default:   o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Instruction-memory writer: accepts symbolic instructions over valid/ready,
// encodes them and writes consecutive words starting at BASE_ADDR.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0,
    parameter int DEPTH     = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              clear_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [3:0]        cls_i,
    input  logic [4:0]        rs_i,
    input  logic [4:0]        rt_i,
    input  logic [4:0]        rd_i,
    input  logic [15:0]       imm_i,
    input  logic [25:0]       target_i,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [31:0]       imem_data_o,
    output logic [ADDR_W:0]   count_o,
    output logic              full_o,
    output logic              error_o
);

    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);

    logic [1:0]        r_state, w_state_nx;
    logic [ADDR_W:0]   r_count, w_count_nx;
    logic              r_ready, w_ready_nx;
    logic              r_we, r_err;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_data;
    logic [31:0]       w_word;
    logic              w_illegal, w_acc, w_wr;

    instr_word_pack u_pack (
        .i_cls    (cls_i),
        .i_rs     (rs_i),
        .i_rt     (rt_i),
        .i_rd     (rd_i),
        .i_imm    (imm_i),
        .i_target (target_i),
        .o_word   (w_word),
        .o_illegal(w_illegal)
    );

    // clear_i and start_i outrank the handshake, so an offered word is dropped then
    assign w_acc = valid_i & r_ready & ~clear_i & ~start_i;
    assign w_wr  = w_acc & ~w_illegal;

    always_comb begin
        w_state_nx = r_state;
        w_count_nx = r_count;
        if (clear_i) begin
            w_state_nx = ST_IDLE;
        end else if (start_i) begin
            w_state_nx = ST_RUN;
            w_count_nx = '0;
        end else begin
            if (w_wr)
                w_count_nx = r_count + (ADDR_W+1)'(1);
            if (r_state == ST_RUN && w_count_nx == DEPTH_C)
                w_state_nx = ST_FULL;
        end
        // ready looks ahead at the post-write count so no accept lands past DEPTH
        w_ready_nx = (w_state_nx == ST_RUN) && (w_count_nx < DEPTH_C);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_ready <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= BASE_C;
            r_data  <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_count <= w_count_nx;
            r_ready <= w_ready_nx;
            r_we    <= w_wr;
            if (w_wr) begin
                r_addr <= BASE_C + r_count[ADDR_W-1:0];
                r_data <= w_word;
            end else if (start_i && !clear_i) begin
                r_addr <= BASE_C;
            end
            if (clear_i)
                r_err <= 1'b0;
            else if (w_acc && w_illegal)
                r_err <= 1'b1;
        end
    end

    assign ready_o     = r_ready;
    assign imem_we_o   = r_we;
    assign imem_addr_o = r_addr;
    assign imem_data_o = r_data;
    assign count_o     = r_count;
    assign full_o      = (r_state == ST_FULL);
    assign error_o     = r_err;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: encoding table plus handshake/FSM corner sequences.
module tb_instr_encoder;

    localparam int ADDR_W = 8;
    localparam int BASE   = 16;
    localparam int DEPTH  = 4;

    logic              clk_i = 1'b0;
    logic              rst_i, start_i, clear_i, valid_i;
    logic              ready_o, imem_we_o, full_o, error_o;
    logic [3:0]        cls_i;
    logic [4:0]        rs_i, rt_i, rd_i;
    logic [15:0]       imm_i;
    logic [25:0]       target_i;
    logic [ADDR_W-1:0] imem_addr_o;
    logic [31:0]       imem_data_o;
    logic [ADDR_W:0]   count_o;

    int n_tests = 0;
    int n_fail  = 0;

    instr_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .clear_i(clear_i),
        .valid_i(valid_i), .ready_o(ready_o), .cls_i(cls_i), .rs_i(rs_i),
        .rt_i(rt_i), .rd_i(rd_i), .imm_i(imm_i), .target_i(target_i),
        .imem_we_o(imem_we_o), .imem_addr_o(imem_addr_o), .imem_data_o(imem_data_o),
        .count_o(count_o), .full_o(full_o), .error_o(error_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [3:0]  cls;
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm;
        logic [25:0] tgt;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[15];

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] c, input logic [4:0] s, input logic [4:0] t,
                         input logic [4:0] d, input logic [15:0] im, input logic [25:0] tg);
        cls_i = c; rs_i = s; rt_i = t; rd_i = d; imm_i = im; target_i = tg;
    endtask

    task automatic do_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    int writes;

    initial begin
        rst_i = 1'b0; start_i = 1'b0; clear_i = 1'b0; valid_i = 1'b1;
        drive(4'd0, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0);

        // reset held two cycles with valid high
        tick(); tick();
        chk("rst_ready", 32'(ready_o), 32'd0);
        chk("rst_we", 32'(imem_we_o), 32'd0);
        chk("rst_count", 32'(count_o), 32'd0);
        chk("rst_err", 32'(error_o), 32'd0);
        chk("rst_full", 32'(full_o), 32'd0);
        chk("rst_addr", 32'(imem_addr_o), BASE);
        chk("rst_data", imem_data_o, 32'd0);
        valid_i = 1'b0;
        rst_i = 1'b1;
        tick();
        chk("idle_ready", 32'(ready_o), 32'd0);

        // encoding table; noise in unused fields must not leak into the word
        vecs[0]  = '{4'd0,  5'd1,  5'd2,  5'd3,  16'hFFFF, 26'h0,       32'h00221820};
        vecs[1]  = '{4'd1,  5'd4,  5'd5,  5'd6,  16'hFFFF, 26'h3FFFFFF, 32'h00853022};
        vecs[2]  = '{4'd2,  5'd7,  5'd8,  5'd9,  16'hFFFF, 26'h0,       32'h00E84824};
        vecs[3]  = '{4'd3,  5'd31, 5'd31, 5'd31, 16'h0,    26'h0,       32'h03FFF825};
        vecs[4]  = '{4'd4,  5'd1,  5'd2,  5'd3,  16'hFFFF, 26'h0,       32'h0022182A};
        vecs[5]  = '{4'd5,  5'd1,  5'd2,  5'd31, 16'h0005, 26'h3FFFFFF, 32'h20220005};
        vecs[6]  = '{4'd6,  5'd3,  5'd4,  5'd31, 16'hFFFF, 26'h0,       32'h2464FFFF};
        vecs[7]  = '{4'd7,  5'd5,  5'd6,  5'd31, 16'h1234, 26'h0,       32'h34A61234};
        vecs[8]  = '{4'd8,  5'd7,  5'd8,  5'd31, 16'hABCD, 26'h0,       32'h3C08ABCD};
        vecs[9]  = '{4'd9,  5'd0,  5'd4,  5'd31, 16'h0008, 26'h0,       32'h8C040008};
        vecs[10] = '{4'd10, 5'd29, 5'd31, 5'd1,  16'hFFFC, 26'h0,       32'hAFBFFFFC};
        vecs[11] = '{4'd11, 5'd1,  5'd2,  5'd31, 16'hFFFE, 26'h0,       32'h1022FFFE};
        vecs[12] = '{4'd12, 5'd3,  5'd0,  5'd31, 16'h0007, 26'h0,       32'h14600007};
        vecs[13] = '{4'd13, 5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h10,      32'h08000010};
        vecs[14] = '{4'd14, 5'd0,  5'd0,  5'd0,  16'h0,    26'h3FFFFFF, 32'h0FFFFFFF};

        for (int i = 0; i < 15; i++) begin
            do_start();
            drive(vecs[i].cls, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].imm, vecs[i].tgt);
            valid_i = 1'b1;
            tick();
            valid_i = 1'b0;
            chk($sformatf("vec%0d_we", i), 32'(imem_we_o), 32'd1);
            chk($sformatf("vec%0d_addr", i), 32'(imem_addr_o), BASE);
            chk($sformatf("vec%0d_data", i), imem_data_o, vecs[i].exp);
        end

        // back-to-back accepts, one write per cycle
        do_start();
        valid_i = 1'b1;
        drive(4'd5, 5'd1, 5'd2, 5'd0, 16'd5, 26'd0);
        tick();
        chk("b2b0_we", 32'(imem_we_o), 32'd1);
        chk("b2b0_addr", 32'(imem_addr_o), BASE);
        chk("b2b0_data", imem_data_o, 32'h20220005);
        drive(4'd9, 5'd0, 5'd4, 5'd0, 16'd8, 26'd0);
        tick();
        chk("b2b1_we", 32'(imem_we_o), 32'd1);
        chk("b2b1_addr", 32'(imem_addr_o), BASE + 1);
        chk("b2b1_data", imem_data_o, 32'h8C040008);
        drive(4'd13, 5'd0, 5'd0, 5'd0, 16'd0, 26'h10);
        tick();
        valid_i = 1'b0;
        chk("b2b2_we", 32'(imem_we_o), 32'd1);
        chk("b2b2_addr", 32'(imem_addr_o), BASE + 2);
        chk("b2b2_data", imem_data_o, 32'h08000010);
        tick();
        chk("b2b_idle_we", 32'(imem_we_o), 32'd0);
        chk("b2b_count", 32'(count_o), 32'd3);

        // fill to DEPTH with valid held high
        do_start();
        drive(4'd0, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0);
        valid_i = 1'b1;
        writes = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (imem_we_o) begin
                chk($sformatf("fill_addr%0d", writes), 32'(imem_addr_o), BASE + writes);
                writes++;
            end
            if (c == 3) begin
                chk("fill_ready_drop", 32'(ready_o), 32'd0);
                chk("fill_full_now", 32'(full_o), 32'd1);
            end
        end
        chk("fill_writes", writes, DEPTH);
        chk("fill_full", 32'(full_o), 32'd1);
        chk("fill_ready", 32'(ready_o), 32'd0);
        chk("fill_count", 32'(count_o), DEPTH);
        valid_i = 1'b0;
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        chk("clr_full", 32'(full_o), 32'd0);
        chk("clr_ready", 32'(ready_o), 32'd0);
        // start in IDLE with valid high: no accept
        start_i = 1'b1;
        valid_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk("start_noacc_we", 32'(imem_we_o), 32'd0);
        chk("start_count", 32'(count_o), 32'd0);
        chk("start_ready", 32'(ready_o), 32'd1);
        tick();
        valid_i = 1'b0;
        chk("restart_we", 32'(imem_we_o), 32'd1);
        chk("restart_addr", 32'(imem_addr_o), BASE);

        // clear beats an offered word
        valid_i = 1'b1;
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        valid_i = 1'b0;
        chk("clr_drop_we", 32'(imem_we_o), 32'd0);
        chk("clr_drop_count", 32'(count_o), 32'd1);

        // illegal class: consumed, sticky error
        do_start();
        drive(4'd15, 5'd1, 5'd2, 5'd3, 16'hFFFF, 26'h3FFFFFF);
        valid_i = 1'b1;
        tick();
        chk("ill_we", 32'(imem_we_o), 32'd0);
        chk("ill_count", 32'(count_o), 32'd0);
        chk("ill_err", 32'(error_o), 32'd1);
        drive(4'd0, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0);
        tick();
        valid_i = 1'b0;
        chk("ill_good_we", 32'(imem_we_o), 32'd1);
        chk("ill_good_addr", 32'(imem_addr_o), BASE);
        chk("ill_good_count", 32'(count_o), 32'd1);
        chk("ill_err_sticky", 32'(error_o), 32'd1);
        tick();
        chk("ill_err_hold", 32'(error_o), 32'd1);
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        chk("ill_err_clr", 32'(error_o), 32'd0);

        // reset right after an accept
        do_start();
        drive(4'd1, 5'd4, 5'd5, 5'd6, 16'd0, 26'd0);
        valid_i = 1'b1;
        tick();
        chk("mid_we_before", 32'(imem_we_o), 32'd1);
        rst_i = 1'b0;
        tick();
        chk("mid_rst_we", 32'(imem_we_o), 32'd0);
        chk("mid_rst_ready", 32'(ready_o), 32'd0);
        chk("mid_rst_count", 32'(count_o), 32'd0);
        chk("mid_rst_addr", 32'(imem_addr_o), BASE);
        chk("mid_rst_data", imem_data_o, 32'd0);
        chk("mid_rst_full", 32'(full_o), 32'd0);
        chk("mid_rst_err", 32'(error_o), 32'd0);
        rst_i = 1'b1;
        tick();
        chk("post_rst_we", 32'(imem_we_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
